// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-masked single-port SRAM.
package sram_pkg;

    // Controller states: sequential clear after reset, then normal access.
    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    // Supported read latencies.
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    // Number of 8-bit write lanes in a word.
    function automatic int laneCount(input int dataW);
        return dataW / 8;
    endfunction

    // True when the word width splits into whole bytes and the latency is supported.
    function automatic bit paramsLegal(input int dataW, input int readLat);
        return ((dataW % 8) == 0) && (readLat >= READ_LAT_MIN) && (readLat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/sram_bw_array.sv
// Raw storage: byte-masked write port and a registered, held read port.
module sram_bw_array
    import sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH),
    localparam int LANES = laneCount(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [LANES-1:0]  i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array contents survive reset; only enabled byte lanes are overwritten.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register holds its value until the next accepted read and clears on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_sp_bw_init.sv
// Single-port SRAM with per-byte write mask, post-reset hardware clear,
// configurable read latency, read-valid strobe and access-error pulse.
module sram_sp_bw_init
    import sram_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 1024,
    parameter int                ADDR_W     = $clog2(DEPTH),
    parameter int                READ_LAT   = 1,
    parameter int                INIT_CLEAR = 1,
    parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic                         CEN,
    input  logic                         WEN,
    input  logic [laneCount(DATA_W)-1:0] BWEN,
    input  logic [ADDR_W-1:0]            A,
    input  logic [DATA_W-1:0]            D,
    output logic [DATA_W-1:0]            Q,
    output logic                         Q_VALID,
    output logic                         BUSY,
    output logic                         ERR
);

    localparam int                LANES       = laneCount(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam state_t            RESET_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

    generate
        if (!paramsLegal(DATA_W, READ_LAT)) begin : g_badParams
            $error("sram_sp_bw_init: DATA_W must be a multiple of 8 and READ_LAT must be 1 or 2");
        end
    endgenerate

    state_t            r_state;
    state_t            w_stateNext;
    logic [ADDR_W-1:0] r_clearCnt;
    logic [ADDR_W-1:0] w_clearCntNext;

    logic              w_busy;
    logic              w_access;
    logic              w_inRange;
    logic              w_accept;
    logic              w_dropNow;
    logic              w_rdOor;

    logic              w_arrWe;
    logic              w_arrRe;
    logic [LANES-1:0]  w_arrBe;
    logic [ADDR_W-1:0] w_arrAddr;
    logic [DATA_W-1:0] w_arrWdata;
    logic [DATA_W-1:0] w_arrRdata;

    logic              r_vld1;
    logic              r_errRd1;
    logic              r_errNow;

    // State and clear-counter registers; reset restarts any clear from address 0.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= RESET_STATE;
            r_clearCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_clearCnt <= w_clearCntNext;
        end
    end

    // Clear walks every address once, leaving READY on the cycle that writes the last word.
    always_comb begin
        w_stateNext    = r_state;
        w_clearCntNext = r_clearCnt;
        if (r_state == ST_CLEAR) begin
            if (r_clearCnt == LAST_ADDR) begin
                w_stateNext    = ST_READY;
                w_clearCntNext = '0;
            end else begin
                w_clearCntNext = r_clearCnt + 1'b1;
            end
        end
    end

    assign w_busy    = (r_state == ST_CLEAR);
    assign w_access  = ~CEN;
    assign w_inRange = (32'(A) < DEPTH);
    assign w_accept  = w_access & ~w_busy & w_inRange;

    // Busy drops and out-of-range writes flag on the next cycle; out-of-range
    // reads flag later so the pulse lines up with where Q_VALID would have been.
    assign w_dropNow = w_access & (w_busy | (~w_inRange & ~WEN));
    assign w_rdOor   = w_access & ~w_busy & ~w_inRange & WEN;

    // The clear owns the write port while busy, forcing all lanes to the fill word.
    assign w_arrWe    = w_busy | (w_accept & ~WEN);
    assign w_arrBe    = w_busy ? {LANES{1'b1}} : ~BWEN;
    assign w_arrAddr  = w_busy ? r_clearCnt : A;
    assign w_arrWdata = w_busy ? FILL_VALUE : D;
    assign w_arrRe    = w_accept & WEN;

    sram_bw_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_we    (w_arrWe),
        .i_be    (w_arrBe),
        .i_addr  (w_arrAddr),
        .i_wdata (w_arrWdata),
        .i_re    (w_arrRe),
        .o_rdata (w_arrRdata)
    );

    // First pipeline stage: read-valid and error flags, all discarded on reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_vld1   <= 1'b0;
            r_errRd1 <= 1'b0;
            r_errNow <= 1'b0;
        end else begin
            r_vld1   <= w_arrRe;
            r_errRd1 <= w_rdOor;
            r_errNow <= w_dropNow;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              r_vld2;
            logic              r_errRd2;
            logic [DATA_W-1:0] r_q2;

            // Extra output stage; Q only captures when fresh read data arrives.
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    r_vld2   <= 1'b0;
                    r_errRd2 <= 1'b0;
                    r_q2     <= '0;
                end else begin
                    r_vld2   <= r_vld1;
                    r_errRd2 <= r_errRd1;
                    if (r_vld1) begin
                        r_q2 <= w_arrRdata;
                    end
                end
            end

            assign Q       = r_q2;
            assign Q_VALID = r_vld2;
            assign ERR     = r_errNow | r_errRd2;
        end else begin : g_lat1
            assign Q       = w_arrRdata;
            assign Q_VALID = r_vld1;
            assign ERR     = r_errNow | r_errRd1;
        end
    endgenerate

    assign BUSY = w_busy;

endmodule
